// File: rtl/pc_unit.sv
// Program-counter unit: selects the next fetch address from sequential, branch,
// jump, trap and mret sources, with a fetch handshake, halt state and misaligned-target trapping.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [31:0]     TRAP_VECTOR  = 32'h0000_0100,
   parameter int              IALIGN       = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0]      pcmux,
   input  logic [XLEN-1:0] immbj,
   input  logic [XLEN-1:0] jump,
   input  logic            halt_req,
   input  logic            resume,
   input  logic            pc_ready,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic [XLEN-1:0] pc_plus,
   output logic [XLEN-1:0] epc,
   output logic            misalign
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [2:0] SEL_BRANCH = 3'b001;
   localparam logic [2:0] SEL_JUMP   = 3'b010;
   localparam logic [2:0] SEL_TRAP   = 3'b011;
   localparam logic [2:0] SEL_MRET   = 3'b100;

   localparam logic [XLEN-1:0] TRAP_PC = XLEN'(TRAP_VECTOR);

   state_t          state, state_n;
   logic [XLEN-1:0] pc_n, epc_n, target;
   logic            misalign_n, target_bad, redirect;

   assign pc_plus  = pc + XLEN'(4);
   assign redirect = (pcmux == SEL_JUMP) || (pcmux == SEL_BRANCH);
   assign target   = (pcmux == SEL_JUMP) ? {jump[XLEN-1:1], 1'b0} : pc + immbj;

   // Jump targets already have bit 0 cleared, so only branches can fail the 2-byte check.
   assign target_bad = (IALIGN == 2) ? target[0] : (target[1:0] != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so every register
   // updates from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= RESET_VECTOR;
         epc      <= '0;
         misalign <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         epc      <= epc_n;
         misalign <= misalign_n;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case/if tree can leave one unassigned and infer a latch.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      epc_n      = epc;
      misalign_n = 1'b0;
      case (state)
         BOOT: begin
            pc_n    = RESET_VECTOR;
            state_n = RUN;
         end
         RUN: begin
            if (pcmux == SEL_TRAP) begin
               epc_n = pc;
               pc_n  = TRAP_PC;
            end else if (pcmux == SEL_MRET) begin
               pc_n = epc;
            end else if (redirect) begin
               if (target_bad) begin
                  epc_n      = pc;
                  pc_n       = TRAP_PC;
                  misalign_n = 1'b1;
               end else begin
                  pc_n = target;
               end
            end else if (pc_ready) begin
               pc_n = pc_plus;
            end
            // The redirect or advance above still commits on the halting edge.
            if (halt_req) state_n = HALT;
         end
         HALT: begin
            if (pcmux == SEL_TRAP) begin
               epc_n = pc;
               pc_n  = TRAP_PC;
            end
            if (resume && !halt_req) state_n = RUN;
         end
         default: state_n = BOOT;
      endcase
   end

   always_comb begin
      pc_valid = (state == RUN);
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/boot, sequential fetch with stall, redirects,
// misaligned-target trapping for both alignments, trap/mret and halt behaviour.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  pcmux;
   logic [31:0] immbj, jump;
   logic        halt_req, resume, pc_ready;
   logic [31:0] pc, pc_plus, epc;
   logic        pc_valid, misalign;
   logic [31:0] pc2, pc_plus2, epc2;
   logic        pc_valid2, misalign2;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] SEQ = 3'b000, BRANCH = 3'b001, JUMP = 3'b010,
                          TRAP = 3'b011, MRET = 3'b100;

   always #5 clk = ~clk;

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h8000_0000), .TRAP_VECTOR(32'h0000_0100), .IALIGN(4)) dut (
      .clk(clk), .rst_n(rst_n), .pcmux(pcmux), .immbj(immbj), .jump(jump),
      .halt_req(halt_req), .resume(resume), .pc_ready(pc_ready),
      .pc(pc), .pc_valid(pc_valid), .pc_plus(pc_plus), .epc(epc), .misalign(misalign));

   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h0000_0100), .IALIGN(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .pcmux(pcmux), .immbj(immbj), .jump(jump),
      .halt_req(halt_req), .resume(resume), .pc_ready(pc_ready),
      .pc(pc2), .pc_valid(pc_valid2), .pc_plus(pc_plus2), .epc(epc2), .misalign(misalign2));

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic [2:0] mux, input logic [31:0] imm, input logic [31:0] jmp,
                        input logic hreq, input logic res, input logic rdy);
      pcmux = mux; immbj = imm; jump = jmp; halt_req = hreq; resume = res; pc_ready = rdy;
   endtask

   // One rising edge, then sample 1 time unit later, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(SEQ, 0, 0, 0, 0, 1);
      repeat (3) step();
      check("reset_pc", pc, 32'h8000_0000);
      check("reset_valid", pc_valid, 0);
      check("reset_epc", epc, 0);
      check("reset_misalign", misalign, 0);

      rst_n = 1'b1;
      #1;
      check("boot_valid_low", pc_valid, 0);
      step();
      check("boot_valid_high", pc_valid, 1);
      check("boot_pc", pc, 32'h8000_0000);
      check("boot_pc_plus", pc_plus, 32'h8000_0004);

      drive(JUMP, 0, 32'h0, 0, 0, 1);
      step();
      check("jump_zero", pc, 32'h0);

      drive(SEQ, 0, 0, 0, 0, 1);
      step(); check("seq_4", pc, 32'h4);
      step(); check("seq_8", pc, 32'h8);
      step(); check("seq_c", pc, 32'hC);
      pc_ready = 1'b0;
      step(); check("stall1_pc", pc, 32'hC); check("stall1_valid", pc_valid, 1);
      step(); check("stall2_pc", pc, 32'hC); check("stall2_valid", pc_valid, 1);
      pc_ready = 1'b1;
      step(); check("seq_10", pc, 32'h10);

      drive(JUMP, 0, 32'hFFFF_FFFC, 0, 0, 1);
      step();
      check("jump_top", pc, 32'hFFFF_FFFC);
      check("pc_plus_wrap", pc_plus, 32'h0);
      drive(SEQ, 0, 0, 0, 0, 1);
      step(); check("seq_wrap", pc, 32'h0);

      drive(JUMP, 0, 32'h20, 0, 0, 1);
      step(); check("jump_20", pc, 32'h20);
      drive(BRANCH, 32'hFFFF_FFF8, 0, 0, 0, 1);
      step(); check("branch_neg8", pc, 32'h18);
      drive(JUMP, 0, 32'h0000_1001, 0, 0, 1);
      step();
      check("jump_clear_bit0", pc, 32'h1000);
      check("jump_no_misalign", misalign, 0);
      drive(BRANCH, 32'h10, 0, 0, 0, 0);
      step();
      check("branch_not_ready", pc, 32'h1010);
      check("branch_valid", pc_valid, 1);

      drive(JUMP, 0, 32'h40, 0, 0, 1);
      step();
      check("jump_40", pc, 32'h40);
      check("jump_40_ialign2", pc2, 32'h40);
      drive(BRANCH, 32'h6, 0, 0, 0, 1);
      step();
      check("mis_pc", pc, 32'h100);
      check("mis_epc", epc, 32'h40);
      check("mis_pulse", misalign, 1);
      check("ialign2_pc", pc2, 32'h46);
      check("ialign2_no_pulse", misalign2, 0);
      check("ialign2_epc", epc2, 32'h0);
      drive(SEQ, 0, 0, 0, 0, 1);
      step();
      check("mis_pulse_end", misalign, 0);
      check("mis_after_seq", pc, 32'h104);
      check("mis_epc_held", epc, 32'h40);

      drive(JUMP, 0, 32'h200, 0, 0, 1);
      step(); check("jump_200", pc, 32'h200);
      drive(TRAP, 0, 0, 0, 0, 1);
      step();
      check("trap_pc", pc, 32'h100);
      check("trap_epc", epc, 32'h200);
      drive(SEQ, 0, 0, 0, 0, 1);
      repeat (4) step();
      check("post_trap_seq", pc, 32'h110);
      check("epc_stable", epc, 32'h200);
      drive(MRET, 0, 0, 0, 0, 1);
      step(); check("mret_pc", pc, 32'h200);

      drive(TRAP, 0, 0, 0, 0, 1);
      rst_n = 1'b0;
      step();
      check("rst_over_trap_pc", pc, 32'h8000_0000);
      check("rst_over_trap_epc", epc, 32'h0);
      check("rst_over_trap_valid", pc_valid, 0);
      rst_n = 1'b1;
      drive(SEQ, 0, 0, 0, 0, 1);
      step();
      check("reboot_pc", pc, 32'h8000_0000);
      check("reboot_valid", pc_valid, 1);

      drive(JUMP, 0, 32'h300, 1, 0, 1);
      step();
      check("halt_jump_pc", pc, 32'h300);
      check("halt_valid", pc_valid, 0);
      drive(SEQ, 0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("halt_hold_pc", pc, 32'h300);
         check("halt_hold_valid", pc_valid, 0);
      end
      drive(TRAP, 0, 0, 0, 0, 1);
      step();
      check("halt_trap_pc", pc, 32'h100);
      check("halt_trap_epc", epc, 32'h300);
      check("halt_trap_valid", pc_valid, 0);
      drive(SEQ, 0, 0, 1, 1, 1);
      step();
      check("resume_blocked", pc_valid, 0);
      drive(SEQ, 0, 0, 0, 1, 1);
      step();
      check("resume_valid", pc_valid, 1);
      check("resume_pc", pc, 32'h100);
      drive(SEQ, 0, 0, 0, 0, 1);
      step();
      check("resume_seq", pc, 32'h104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
